// File: rtl/ud_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ud_sweep_ctrl
// Brief    : Triangular lo/hi sweep sequencer for a W-bit up/down counter.
//            Optional window check enabled by UD_SWEEP_WINDOW_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ud_sweep_ctrl #(
  parameter int W       = 4,
  parameter int DWELL   = 3,
  parameter int NSWEEPS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] cnt_in,
  output logic         cnt_clr,
  output logic         cnt_en,
  output logic         ud,
  output logic         busy,
  output logic         done,
  output logic         abort,
  output logic         err,
  output logic         fault,
  output logic [7:0]   sweeps
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_SEEK     = 3'd2,
    S_UP       = 3'd3,
    S_DWELL_HI = 3'd4,
    S_DOWN     = 3'd5,
    S_DWELL_LO = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  // A zero dwell still spends the single entry cycle in the dwell state.
  localparam logic [3:0] c_dwell_load = (DWELL == 0) ? 4'd0 : 4'(DWELL - 1);
  localparam logic [7:0] c_nsweeps    = 8'(NSWEEPS);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_hi;
  logic [3:0]   r_dwell;
  logic [7:0]   r_sweeps;
  logic         r_cnt_clr;
  logic         r_busy;
  logic         r_done;
  logic         r_abort;
  logic         r_err;
  logic         r_fault;

  logic         w_accept;
  logic         w_reject;
  logic         w_stop_hit;
  logic         w_fault_hit;
  logic         w_sweep_inc;
  logic         w_window_bad;
  logic         w_in_dwell;
  logic [7:0]   w_sweeps_nxt;

  assign w_sweeps_nxt = (r_sweeps == 8'hFF) ? r_sweeps : r_sweeps + 8'd1;
  assign w_in_dwell   = (r_state == S_DWELL_HI) || (r_state == S_DWELL_LO);

`ifdef UD_SWEEP_WINDOW_CHECK_EN
  assign w_window_bad = ((r_state == S_UP) || (r_state == S_DOWN) || w_in_dwell) &&
                        ((cnt_in < r_lo) || (cnt_in > r_hi));
`else
  assign w_window_bad = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    cnt_en      = 1'b0;
    ud          = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_stop_hit  = 1'b0;
    w_fault_hit = 1'b0;
    w_sweep_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (lo < hi) begin
            w_accept = 1'b1;
            w_next   = S_CLEAR;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_CLEAR: w_next = S_SEEK;
      S_SEEK: begin
        ud     = 1'b1;
        cnt_en = (cnt_in != r_lo);
        if (cnt_in == r_lo) w_next = S_UP;
      end
      S_UP: begin
        ud     = 1'b1;
        cnt_en = (cnt_in != r_hi);
        if (cnt_in == r_hi) w_next = S_DWELL_HI;
      end
      S_DWELL_HI: begin
        if (r_dwell == 4'd0) w_next = S_DOWN;
      end
      S_DOWN: begin
        cnt_en = (cnt_in != r_lo);
        if (cnt_in == r_lo) begin
          w_sweep_inc = 1'b1;
          if ((c_nsweeps != 8'd0) && (w_sweeps_nxt == c_nsweeps)) w_next = S_DONE;
          else                                                    w_next = S_DWELL_LO;
        end
      end
      S_DWELL_LO: begin
        ud = 1'b1;
        if (r_dwell == 4'd0) w_next = S_UP;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    // Abort paths override whatever the state decode chose.
    if (r_state != S_IDLE) begin
      if (stop) begin
        w_stop_hit  = 1'b1;
        w_next      = S_IDLE;
        cnt_en      = 1'b0;
        w_sweep_inc = 1'b0;
      end else if (w_window_bad) begin
        w_fault_hit = 1'b1;
        w_next      = S_IDLE;
        cnt_en      = 1'b0;
        w_sweep_inc = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_dwell   <= 4'd0;
      r_sweeps  <= 8'd0;
      r_cnt_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_err     <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt_clr <= (w_next == S_CLEAR);
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_abort   <= w_stop_hit;
      r_err     <= w_reject;
      r_fault   <= w_fault_hit;

      if (w_accept) begin
        r_lo     <= lo;
        r_hi     <= hi;
        r_sweeps <= 8'd0;
      end else if (w_sweep_inc) begin
        r_sweeps <= w_sweeps_nxt;
      end

      if (((w_next == S_DWELL_HI) || (w_next == S_DWELL_LO)) && (w_next != r_state))
        r_dwell <= c_dwell_load;
      else if (w_in_dwell && (r_dwell != 4'd0))
        r_dwell <= r_dwell - 4'd1;
    end
  end

  assign cnt_clr = r_cnt_clr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign abort   = r_abort;
  assign err     = r_err;
  assign fault   = r_fault;
  assign sweeps  = r_sweeps;

endmodule
`default_nettype wire

// File: tb/tb_ud_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ud_sweep_ctrl
// Brief    : Directed self-checking bench for ud_sweep_ctrl with a counter model
//            and a per-cycle expected-trace scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ud_sweep_ctrl;

  localparam int W     = 4;
  localparam int DWELL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (NSWEEPS=2)
  logic         start = 1'b0, stop = 1'b0;
  logic [W-1:0] lo = '0, hi = '0;
  logic [W-1:0] cnt_q = '0, cnt_in;
  logic         ovr_en = 1'b0;
  logic [W-1:0] ovr_val = '0;
  logic         cnt_clr, cnt_en, ud, busy, done, abort, err, fault;
  logic [7:0]   sweeps;

  assign cnt_in = ovr_en ? ovr_val : cnt_q;

  ud_sweep_ctrl #(.W(W), .DWELL(DWELL), .NSWEEPS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi),
    .cnt_in(cnt_in), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .ud(ud), .busy(busy),
    .done(done), .abort(abort), .err(err), .fault(fault), .sweeps(sweeps));

  always @(posedge clk)
    if (cnt_clr)     cnt_q <= '0;
    else if (cnt_en) cnt_q <= ud ? cnt_q + 4'd1 : cnt_q - 4'd1;

  // Free-running instance (NSWEEPS=0)
  logic         start0 = 1'b0, stop0 = 1'b0;
  logic [W-1:0] lo0 = '0, hi0 = '0;
  logic [W-1:0] cnt0 = '0;
  logic         cnt_clr0, cnt_en0, ud0, busy0, done0, abort0, err0, fault0;
  logic [7:0]   sweeps0;

  ud_sweep_ctrl #(.W(W), .DWELL(DWELL), .NSWEEPS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .lo(lo0), .hi(hi0),
    .cnt_in(cnt0), .cnt_clr(cnt_clr0), .cnt_en(cnt_en0), .ud(ud0), .busy(busy0),
    .done(done0), .abort(abort0), .err(err0), .fault(fault0), .sweeps(sweeps0));

  always @(posedge clk)
    if (cnt_clr0)     cnt0 <= '0;
    else if (cnt_en0) cnt0 <= ud0 ? cnt0 + 4'd1 : cnt0 - 4'd1;

  typedef struct packed {
    logic         clr;
    logic         en;
    logic         ud;
    logic         udx;
    logic [W-1:0] cnt;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic clr, input logic en, input logic u, input logic udx,
                      input int cnt, input logic d);
    exp_t e;
    e.clr = clr; e.en = en; e.ud = u; e.udx = udx; e.cnt = W'(cnt); e.done = d;
    sb.push_back(e);
  endtask

  // One counting leg: one enabled cycle per step, then the endpoint detect cycle.
  task automatic push_leg(input int from, input int to, input logic up);
    int v = from;
    while (v != to) begin
      push(1'b0, 1'b1, up, 1'b0, v, 1'b0);
      v = up ? v + 1 : v - 1;
    end
    push(1'b0, 1'b0, up, 1'b0, to, 1'b0);
  endtask

  task automatic push_dwell(input logic u, input int cnt);
    for (int i = 0; i < DWELL; i++) push(1'b0, 1'b0, u, 1'b0, cnt, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   idx;
    bit   found;
    bit   wrapped, saw_done0, saw_top;
    logic [W-1:0] prev;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);   chk("rst.cnt_clr", cnt_clr, 0);
    chk("rst.cnt_en", cnt_en, 0); chk("rst.ud", ud, 0);
    chk("rst.done", done, 0);   chk("rst.abort", abort, 0);
    chk("rst.err", err, 0);     chk("rst.fault", fault, 0);
    chk("rst.sweeps", sweeps, 0);
    rst = 1'b0;
    tick();

    // Full run lo=2 hi=5, two sweeps
    push(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    push_leg(0, 2, 1'b1);
    for (int s = 0; s < 2; s++) begin
      push_leg(2, 5, 1'b1);
      push_dwell(1'b0, 5);
      push_leg(5, 2, 1'b0);
      if (s == 0) push_dwell(1'b1, 2);
    end
    push(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1);

    lo = 4'd2; hi = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("trace[%0d].cnt_clr", idx), cnt_clr, e.clr);
      chk($sformatf("trace[%0d].cnt_en", idx), cnt_en, e.en);
      if (!e.udx) chk($sformatf("trace[%0d].ud", idx), ud, e.ud);
      chk($sformatf("trace[%0d].cnt", idx), cnt_in, e.cnt);
      chk($sformatf("trace[%0d].done", idx), done, e.done);
      chk($sformatf("trace[%0d].busy", idx), busy, 1);
      if (e.done) chk("run.sweeps_at_done", sweeps, 2);
      idx++;
      tick();
    end
    chk("run.busy_after", busy, 0);
    chk("run.done_after", done, 0);
    chk("run.sweeps_hold", sweeps, 2);
    chk("run.cnt_final", cnt_in, 2);

    // Rejected starts
    lo = 4'd7; hi = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej1.err", err, 1); chk("rej1.busy", busy, 0); chk("rej1.cnt_en", cnt_en, 0);
    tick();
    chk("rej1.err_low", err, 0); chk("rej1.busy_low", busy, 0);
    lo = 4'd9; hi = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej2.err", err, 1); chk("rej2.busy", busy, 0); chk("rej2.cnt_en", cnt_en, 0);
    tick();
    chk("rej2.err_low", err, 0); chk("rej2.sweeps", sweeps, 2);

    // Stop during DOWN at cnt 4
    lo = 4'd2; hi = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (busy && !ud && cnt_en && cnt_in == 4'd4) found = 1'b1;
      else tick();
    end
    chk("stop.reach_down4", found, 1);
    stop = 1'b1;
    #1;
    chk("stop.cnt_en", cnt_en, 0);
    tick();
    stop = 1'b0;
    chk("stop.abort", abort, 1); chk("stop.busy", busy, 0);
    chk("stop.cnt_hold", cnt_in, 4); chk("stop.sweeps", sweeps, 0);
    tick();
    chk("stop.abort_low", abort, 0); chk("stop.cnt_hold2", cnt_in, 4);

    // Window violation in UP
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (busy && ud && cnt_en && cnt_in == 4'd3) found = 1'b1;
      else tick();
    end
    chk("win.reach_up3", found, 1);
    ovr_val = 4'd7; ovr_en = 1'b1;
    tick();
`ifdef UD_SWEEP_WINDOW_CHECK_EN
    chk("win.fault", fault, 1); chk("win.busy", busy, 0);
`else
    chk("win.fault", fault, 0); chk("win.busy", busy, 1);
`endif
    ovr_en = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("win.fault_low", fault, 0); chk("win.idle", busy, 0);
    tick();

    // Free-running sweep 0..15 on the NSWEEPS=0 instance
    lo0 = 4'd0; hi0 = 4'd15; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wrapped = 1'b0; saw_done0 = 1'b0; saw_top = 1'b0; found = 1'b0;
    prev = cnt0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if ((prev == 4'd15 && cnt0 == 4'd0) || (prev == 4'd0 && cnt0 == 4'd15)) wrapped = 1'b1;
      if (done0) saw_done0 = 1'b1;
      if (cnt0 == 4'd15) saw_top = 1'b1;
      prev = cnt0;
      if (sweeps0 == 8'd3) found = 1'b1;
    end
    chk("free.reach3", found, 1);
    chk("free.no_wrap", wrapped, 0);
    chk("free.no_done", saw_done0, 0);
    chk("free.reached_hi", saw_top, 1);
    chk("free.busy", busy0, 1);
    stop0 = 1'b1;
    tick();
    stop0 = 1'b0;
    chk("free.abort", abort0, 1); chk("free.sweeps", sweeps0, 3); chk("free.idle", busy0, 0);

    // Asynchronous reset mid-SEEK
    lo = 4'd5; hi = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busy && ud && cnt_en && cnt_in == 4'd1) found = 1'b1;
      else tick();
    end
    chk("arst.reach_seek", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", busy, 0); chk("arst.cnt_en", cnt_en, 0);
    chk("arst.done", done, 0); chk("arst.sweeps", sweeps, 0); chk("arst.ud", ud, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst.cnt_kept", cnt_in, 1); chk("arst.idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
